fifo_wr_arbiter: RTL



---
 rtl/fifo_wr_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin write arbiter that shares one FIFO push port between
//            NREQ valid/ready requesters. The granted owner may push up to
//            MAX_BURST consecutive words before the grant rotates.
// Ports    : i_clk, i_rst        - clock, synchronous active-high reset
//            i_req_valid/data    - per-requester valid and packed data
//            o_req_ready         - per-requester accept (one-hot or zero)
//            i_fifo_full         - FIFO full flag
//            o_fifo_push/wdata   - FIFO write strobe and data (same cycle)
//            o_grant_id          - requester transferring now (0 when none)
//            o_busy              - high while a burst owner holds the port
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NREQ-1:0]           i_req_valid,
    input  logic [NREQ*WIDTH-1:0]     i_req_data,
    output logic [NREQ-1:0]           o_req_ready,
    input  logic                      i_fifo_full,
    output logic                      o_fifo_push,
    output logic [WIDTH-1:0]          o_fifo_wdata,
    output logic [$clog2(NREQ)-1:0]   o_grant_id,
    output logic                      o_busy
);

    localparam int c_IW = $clog2(NREQ);
    localparam int c_SW = c_IW + 1;            // holds ptr + offset before wrap
    localparam int c_CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_OWN  = 1'b1;

    logic [0:0]      r_state;
    logic [c_IW-1:0] r_ptr;
    logic [c_IW-1:0] r_owner;
    logic [c_CW-1:0] r_cnt;

    logic            w_any;
    logic [c_IW-1:0] w_pick;
    logic [NREQ-1:0] w_ready;
    logic            w_xfer;
    logic [WIDTH-1:0] w_wdata;
    logic [c_IW-1:0] w_gid;

    function automatic logic [c_IW-1:0] f_next(input logic [c_IW-1:0] x);
        if (x == c_IW'(NREQ - 1))
            return '0;
        return x + c_IW'(1);
    endfunction

    // Round-robin search starting at r_ptr; the first valid hit wins.
    always_comb begin
        logic [c_SW-1:0] sum;
        logic [c_IW-1:0] idx;
        sum    = '0;
        idx    = '0;
        w_any  = 1'b0;
        w_pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, r_ptr} + c_SW'(i);
            if (sum >= c_SW'(NREQ))
                sum = sum - c_SW'(NREQ);
            idx = sum[c_IW-1:0];
            if (!w_any && i_req_valid[idx]) begin
                w_any  = 1'b1;
                w_pick = idx;
            end
        end
    end

    // Ready is never raised while the FIFO is full or reset is asserted.
    always_comb begin
        w_ready = '0;
        if (!i_rst && !i_fifo_full) begin
            if (r_state == c_ST_OWN)
                w_ready[r_owner] = 1'b1;
            else if (w_any)
                w_ready[w_pick] = 1'b1;
        end
    end

    assign w_xfer = |(w_ready & i_req_valid);

    always_comb begin
        w_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_ready[k] && i_req_valid[k])
                w_wdata = i_req_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        w_gid = '0;
        if (w_xfer)
            w_gid = (r_state == c_ST_OWN) ? r_owner : w_pick;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_xfer) begin
                        if (MAX_BURST == 1) begin
                            r_ptr <= f_next(w_pick);
                        end else begin
                            r_state <= c_ST_OWN;
                            r_owner <= w_pick;
                            r_cnt   <= c_CW'(1);
                        end
                    end
                end
                c_ST_OWN: begin
                    if (!i_req_valid[r_owner]) begin
                        // Owner went quiet: give up the port (one bubble).
                        r_state <= c_ST_IDLE;
                        r_ptr   <= f_next(r_owner);
                        r_cnt   <= '0;
                    end else if (!i_fifo_full) begin
                        if (r_cnt == c_CW'(MAX_BURST - 1)) begin
                            r_state <= c_ST_IDLE;
                            r_ptr   <= f_next(r_owner);
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready  = w_ready;
    assign o_fifo_push  = w_xfer;
    assign o_fifo_wdata = w_wdata;
    assign o_grant_id   = w_gid;
    assign o_busy       = (r_state == c_ST_OWN);

endmodule
`default_nettype wire
